// File: rtl/cmos_pixel_packer_if.sv
// cmos_pixel_packer_if: RGB565 pixel stream in, frame-buffer FIFO write port out
interface cmos_pixel_packer_if #(
    parameter int OUT_W = 128
);
    logic             vs_i;
    logic             pix_valid_i;
    logic [15:0]      pix_data_i;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [OUT_W-1:0] fifo_wr_data;

    modport master (
        output vs_i, pix_valid_i, pix_data_i, fifo_full,
        input  fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  vs_i, pix_valid_i, pix_data_i, fifo_full,
        output fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/cmos_pixel_packer.sv
// cmos_pixel_packer: packs RGB565 pixels into FIFO words per frame; define CMOS_PACKER_RB_SWAP_EN to swap R/B fields
module cmos_pixel_packer #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int OUT_W    = 128
) (
    input  logic               pclk,
    input  logic               rst_n,
    cmos_pixel_packer_if.slave bus,
    input  logic               err_clr_i,
    output logic               frame_start,
    output logic               frame_done,
    output logic [11:0]        line_cnt,
    output logic               err_overflow,
    output logic               err_short
);
    localparam int PPW = OUT_W / 16;
    localparam int LW  = $clog2(PPW);

    typedef enum logic [1:0] {WAIT_VS, SYNC, ACTIVE, DROP} state_t;

    state_t               state, state_nxt;
    logic                 vs_d, vs_rise, vs_fall;
    logic [11:0]          x, y;
    logic [LW-1:0]        lane;
    logic [PPW-1:0][15:0] pack, word_nxt;
    logic [15:0]          pix;
    logic                 start, short_set, accept, complete, ovf, wr, line_end, last;

    assign vs_rise  = bus.vs_i & ~vs_d;
    assign vs_fall  = ~bus.vs_i & vs_d;
    assign line_cnt = y;

`ifdef CMOS_PACKER_RB_SWAP_EN
    assign pix = {bus.pix_data_i[4:0], bus.pix_data_i[10:5], bus.pix_data_i[15:11]};
`else
    assign pix = bus.pix_data_i;
`endif

    // state register
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_VS;
        else        state <= state_nxt;
    end

    // next state: a vsync rise always restarts sync, a lost word poisons the rest of the frame
    always_comb begin
        state_nxt = (state == WAIT_VS || state == DROP) ? (vs_rise ? SYNC : state) :
                    (state == SYNC)                     ? (vs_fall ? ACTIVE : SYNC) :
                    vs_rise                             ? SYNC :
                    ovf                                 ? DROP :
                    last                                ? WAIT_VS : ACTIVE;
    end

    // per-cycle qualifiers; lane is a power-of-two counter so all-ones marks the final lane
    always_comb begin
        start          = state == SYNC && vs_fall;
        short_set      = state == ACTIVE && vs_rise;
        accept         = state == ACTIVE && bus.pix_valid_i && !vs_rise;
        complete       = accept && (&lane);
        ovf            = complete && bus.fifo_full;
        wr             = complete && !bus.fifo_full;
        line_end       = accept && x == 12'(H_ACTIVE - 1);
        last           = line_end && y == 12'(V_ACTIVE - 1);
        word_nxt       = pack;
        word_nxt[lane] = pix;
    end

    // vsync delay, position counters and pack register; y holds on the final line so line_cnt stays in range
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
            x    <= '0;
            y    <= '0;
            lane <= '0;
            pack <= '0;
        end else begin
            vs_d <= bus.vs_i;
            if (start) begin
                x    <= '0;
                y    <= '0;
                lane <= '0;
            end else if (accept) begin
                lane <= lane + 1'b1;
                pack <= word_nxt;
                x    <= line_end ? 12'd0 : x + 1'b1;
                y    <= (line_end && !last) ? y + 1'b1 : y;
            end
        end
    end

    // registered FIFO write, frame pulses and sticky error flags (set beats clear)
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fifo_wr_en   <= 1'b0;
            bus.fifo_wr_data <= '0;
            frame_start      <= 1'b0;
            frame_done       <= 1'b0;
            err_overflow     <= 1'b0;
            err_short        <= 1'b0;
        end else begin
            bus.fifo_wr_en <= wr;
            if (wr) bus.fifo_wr_data <= word_nxt;
            frame_start  <= start;
            frame_done   <= last && wr;
            err_overflow <= ovf | (err_overflow & ~err_clr_i);
            err_short    <= short_set | (err_short & ~err_clr_i);
        end
    end
endmodule

// File: tb/tb_cmos_pixel_packer.sv
// tb_cmos_pixel_packer: randomized frames against a queue-based packing model with a decoupled write monitor
module tb_cmos_pixel_packer;
    localparam int H = 16, V = 2, OW = 64, PPW = OW / 16, TOTAL = H * V;

    typedef struct {
        logic [OW-1:0] w;
        bit            done;
    } exp_t;

    logic        pclk = 0, rst_n = 0, err_clr = 0;
    logic        frame_start, frame_done, err_overflow, err_short;
    logic [11:0] line_cnt;

    exp_t        q[$];
    logic [15:0] cur[$];
    exp_t        mon_e;
    int          checks = 0, errors = 0, pcount = 0, starts_seen = 0, starts_exp = 0;
    bit          m_active = 0, exp_ovf = 0, exp_short = 0;

    cmos_pixel_packer_if #(.OUT_W(OW)) bus ();

    cmos_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .OUT_W(OW)) dut (
        .pclk(pclk), .rst_n(rst_n), .bus(bus.slave), .err_clr_i(err_clr),
        .frame_start(frame_start), .frame_done(frame_done), .line_cnt(line_cnt),
        .err_overflow(err_overflow), .err_short(err_short)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_pix(input logic [15:0] d);
`ifdef CMOS_PACKER_RB_SWAP_EN
        return {d[4:0], d[10:5], d[15:11]};
`else
        return d;
`endif
    endfunction

    // reference: collect accepted pixels, every PPW of them form one word, first pixel lowest
    task automatic model_pix(input logic [15:0] d, input bit full);
        logic [OW-1:0] w;
        if (!m_active) return;
        cur.push_back(ref_pix(d));
        pcount++;
        if (cur.size() == PPW) begin
            for (int j = 0; j < PPW; j++) w[16*j +: 16] = cur[j];
            cur.delete();
            if (full) begin
                m_active = 0;
                exp_ovf  = 1;
            end else begin
                q.push_back('{w, pcount == TOTAL});
                if (pcount == TOTAL) m_active = 0;
            end
        end
    endtask

    task automatic send_pix(input logic [15:0] d, input bit full);
        @(negedge pclk);
        bus.pix_valid_i = 1;
        bus.pix_data_i  = d;
        bus.fifo_full   = full;
        model_pix(d, full);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            bus.pix_valid_i = 0;
            bus.fifo_full   = 1'($urandom);
        end
    endtask

    task automatic pixels(input int n, input int ovf_word, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom % 3 == 0) idle(1);
            send_pix(rnd ? 16'($urandom) : 16'(i),
                     (i % PPW == PPW - 1) ? (i / PPW == ovf_word) : 1'($urandom));
        end
    endtask

    task automatic vs_pulse(input bit with_pix);
        @(negedge pclk);
        bus.vs_i        = 1;
        bus.pix_valid_i = with_pix;
        bus.pix_data_i  = 16'($urandom);
        bus.fifo_full   = 0;
        if (m_active) exp_short = 1;
        m_active = 0;
        cur.delete();
        @(negedge pclk);
        bus.pix_valid_i = 0;
        @(negedge pclk);
        bus.vs_i = 0;
        @(negedge pclk);
        check("frame_start", frame_start, 1);
        check("line_cnt_at_start", line_cnt, 0);
        starts_exp++;
        m_active = 1;
        pcount   = 0;
    endtask

    task automatic settle();
        idle(4);
        check("writes_outstanding", q.size(), 0);
        check("err_overflow", err_overflow, exp_ovf);
        check("err_short", err_short, exp_short);
    endtask

    task automatic clear_errs();
        @(negedge pclk);
        err_clr   = 1;
        exp_ovf   = 0;
        exp_short = 0;
        @(negedge pclk);
        err_clr = 0;
        check("err_overflow_cleared", err_overflow, 0);
        check("err_short_cleared", err_short, 0);
    endtask

    // monitor: every write must match the head of the expected queue; frame_done only with the final write
    always @(negedge pclk) begin
        if (rst_n) begin
            if (frame_start) starts_seen++;
            if (bus.fifo_wr_en) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h required=no_write", bus.fifo_wr_data);
                end else begin
                    mon_e = q.pop_front();
                    check("wr_data", bus.fifo_wr_data, mon_e.w);
                    check("frame_done", frame_done, mon_e.done);
                end
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL frame_done_without_write actual=1 required=0");
            end
        end
    end

    initial begin
        bus.vs_i = 0; bus.pix_valid_i = 0; bus.pix_data_i = 0; bus.fifo_full = 0;
        repeat (3) @(negedge pclk);
        check("rst_wr_en", bus.fifo_wr_en, 0);
        check("rst_wr_data", bus.fifo_wr_data, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_short", err_short, 0);
        @(negedge pclk);
        rst_n = 1;
        pixels(10, -1, 1);
        settle();
        vs_pulse(0);
        pixels(TOTAL, -1, 0);
        settle();
        vs_pulse(0);
        pixels(TOTAL, 2, 1);
        settle();
        vs_pulse(0);
        pixels(TOTAL, -1, 1);
        settle();
        clear_errs();
        vs_pulse(0);
        pixels(18, -1, 1);
        idle(2);
        check("line_cnt_second_line", line_cnt, 1);
        vs_pulse(0);
        pixels(TOTAL, -1, 1);
        settle();
        clear_errs();
        vs_pulse(0);
        pixels(30, -1, 1);
        vs_pulse(1);
        pixels(TOTAL, -1, 1);
        settle();
        clear_errs();
        for (int k = 0; k < 8; k++) begin
            vs_pulse(0);
            pixels(($urandom % 2 == 0) ? TOTAL : int'($urandom_range(1, TOTAL - 1)),
                   ($urandom % 3 == 0) ? int'($urandom_range(0, TOTAL / PPW - 1)) : -1, 1);
            pixels(int'($urandom_range(0, 5)), -1, 1);
            settle();
            clear_errs();
        end
        vs_pulse(0);
        pixels(10, -1, 1);
        @(negedge pclk);
        bus.pix_valid_i = 0;
        rst_n = 0;
        #1;
        check("midrst_wr_en", bus.fifo_wr_en, 0);
        check("midrst_wr_data", bus.fifo_wr_data, 0);
        check("midrst_line_cnt", line_cnt, 0);
        check("midrst_frame_done", frame_done, 0);
        q.delete();
        cur.delete();
        m_active  = 0;
        exp_ovf   = 0;
        exp_short = 0;
        @(negedge pclk);
        rst_n = 1;
        pixels(5, -1, 1);
        settle();
        vs_pulse(0);
        pixels(TOTAL, -1, 1);
        settle();
        check("frame_start_count", starts_seen, starts_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmos_pixel_packer.md
# cmos_pixel_packer

Downstream stage of the CMOS 8-to-16-bit assembler. It takes the RGB565 pixel stream (valid strobe, 16-bit pixel, vsync) on the camera pixel clock and tracks frame and line position. It packs consecutive pixels into wide words and pushes them into the frame-buffer write FIFO. It detects short frames and FIFO overflow, and drops the rest of a corrupted frame so the frame buffer never receives misaligned data.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line. Must be a multiple of PPW.
- V_ACTIVE, 720, active lines per frame.
- OUT_W, 128, FIFO word width. PPW = OUT_W/16 pixels per word; PPW must be a power of two, 2..16.

Ports:
- pclk  in  1  pixel clock. The only clock; all logic is rising-edge.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- vs_i  in  1  vsync from upstream, active high.
- pix_valid_i  in  1  pixel strobe, one cycle per pixel.
- pix_data_i  in  16  RGB565 pixel.
- fifo_full  in  1  write FIFO full.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  OUT_W  packed word; first pixel in bits [15:0].
- frame_start  out  1  one-cycle pulse at the start of a frame.
- frame_done  out  1  one-cycle pulse when a complete frame has been written.
- line_cnt  out  12  current line index, 0..V_ACTIVE-1.
- err_clr_i  in  1  clears the sticky error flags.
- err_overflow  out  1  sticky: a word was lost to fifo_full.
- err_short  out  1  sticky: vsync arrived before the frame was complete.

## Operation
- Edge detection: vs_d is vs_i registered. vs_rise = vs_i & ~vs_d. vs_fall = ~vs_i & vs_d.
- State machine:
  - WAIT_VS (reset state): ignore pixels. On vs_rise go to SYNC.
  - SYNC: ignore pixels. On vs_fall clear x, y and lane counters, pulse frame_start, go to ACTIVE.
  - ACTIVE:
    - On each pix_valid_i, write the pixel into lane `lane` of the pack register, then increment lane (wraps at PPW) and x.
    - When x reaches H_ACTIVE-1: x wraps to 0 and y increments.
    - On the last pixel of line V_ACTIVE-1: pulse frame_done and go to WAIT_VS.
  - DROP: ignore pixels. On vs_rise go to SYNC.
- Word completion: a word is complete when the accepted pixel lands in lane PPW-1.
  - If fifo_full is low in that cycle, the word is written.
  - If fifo_full is high, the word is discarded, err_overflow is set, and the state goes to DROP.
  - frame_done is suppressed even if the lost word was the last word of the frame.
- Short frame: vs_rise while in ACTIVE sets err_short, discards any partial word, and goes to SYNC.
- Priority: vs_rise beats pix_valid_i in the same cycle; that pixel is discarded.
- Error flags: err_clr_i clears both flags. If a set condition occurs in the same cycle, set wins.
- Counters: x and y are 12 bits. line_cnt = y. Pixels arriving in WAIT_VS, SYNC or DROP change no counter.

## Timing
- Reset values: state = WAIT_VS. All outputs are 0, including fifo_wr_data, line_cnt and both error flags. The pack register, counters and vs_d are 0.
- fifo_wr_en and fifo_wr_data are registered. They assert exactly one cycle after the pixel that completes the word, for one cycle.
- fifo_full is sampled combinationally in the completion cycle. No lookahead is required.
- frame_start is registered: it asserts one cycle after the cycle in which vs_fall is detected.
- frame_done asserts in the same cycle as the frame's final fifo_wr_en.
- Throughput: one pixel per cycle sustained, with no bubbles needed. The maximum write rate is one word per PPW cycles.
- Reset mid-frame: everything returns to its reset value immediately. The first frame after reset is always waited out via WAIT_VS→SYNC.

## Configuration
- CMOS_PACKER_RB_SWAP_EN
  - Defined: each pixel is stored as {pix_data_i[4:0], pix_data_i[10:5], pix_data_i[15:11]} (R/B field swap).
  - Undefined: pix_data_i is stored unchanged.
  - No other behaviour or timing differs.

## Test plan
All scenarios use H_ACTIVE=16, V_ACTIVE=2, OUT_W=64 (PPW=4), which gives 8 words per frame.
- Nominal frame:
  - Stimulus: vs pulse, then 32 continuous pixels with values 0x0000..0x001F.
  - Response: frame_start one cycle after vs falls. 8 writes; the first word is 0x0003_0002_0001_0000. line_cnt goes 0→1. frame_done coincides with the 8th write. No error flags set.
- Pre-sync pixels:
  - Stimulus: 10 pixels after reset before any vs, then a nominal frame.
  - Response: no writes before frame_start. The frame is identical to the nominal case.
- Overflow:
  - Stimulus: fifo_full high during completion of word 3.
  - Response: 2 writes only. err_overflow=1, no frame_done. The next frame after vs writes 8 words. err_clr_i clears the flag.
- Short frame:
  - Stimulus: vs rises after 18 pixels.
  - Response: 4 writes, the partial word is dropped, err_short=1, no frame_done. The following frame is nominal.
- Collision:
  - Stimulus: pix_valid_i and vs rise in the same cycle at the 31st pixel.
  - Response: that pixel is discarded and err_short=1.
- Swap build:
  - Stimulus: CMOS_PACKER_RB_SWAP_EN defined, pixel 0xF800.
  - Response: lane value 0x001F.
